// File: rtl/hcache_pkg.sv
// Shared types and helpers for the hash-cache lookup controller.
// Provides the default widths, the controller state encoding and the
// {data, tag} cache-line packing used on the fill port.
package hcache_pkg;

   localparam int unsigned MEM_ADDR_W   = 32;
   localparam int unsigned CACHE_ADDR_W = 13;
   localparam int unsigned DATA_W       = 64;
   localparam int unsigned TAG_W        = MEM_ADDR_W - CACHE_ADDR_W;
   localparam int unsigned CNT_W        = 32;
   localparam int unsigned LINE_W       = DATA_W + TAG_W;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOOKUP   = 3'd1,
      S_WAIT_RD  = 3'd2,
      S_MEM_REQ  = 3'd3,
      S_MEM_WAIT = 3'd4,
      S_FILL     = 3'd5,
      S_RESP     = 3'd6
   } state_e;

   // Cache line as written on the fill port: tag occupies the low bits.
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [TAG_W-1:0]  tag;
   } line_t;

   function automatic line_t pack_line(input logic [DATA_W-1:0] data,
                                       input logic [TAG_W-1:0]  tag);
      line_t l;
      l.data = data;
      l.tag  = tag;
      return l;
   endfunction

endpackage

// File: rtl/hcache_lookup_ctrl_sat_counter.sv
// Saturating statistics counter.
// Ports: clk, rst (sync, active-high), clr_i (clear, wins over inc_i),
//        inc_i (increment, held at all-ones once reached), cnt_o (count).
module sat_counter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] cnt_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   // Clear first, then increment only while below all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/hcache_lookup_ctrl.sv
// Initiator-side lookup/fill controller for the direct-mapped hash cache.
// Upstream:   req_valid/req_ready/req_addr, rsp_valid/rsp_ready/rsp_data/rsp_hit.
// Cache:      cache_rd_* (lookup, result 2 cycles after strobe), cache_wr_* (fill).
// Memory:     mem_req_* (read address), mem_rsp_* (read data).
// Statistics: stats_clr, hit_cnt, miss_cnt (saturating).
// One lookup in flight; every output comes straight from a flop.
module hcache_lookup_ctrl
   import hcache_pkg::*;
#(
   parameter int unsigned C_MEM_ADDR_WIDTH   = MEM_ADDR_W,
   parameter int unsigned C_CACHE_ADDR_WIDTH = CACHE_ADDR_W,
   parameter int unsigned C_DATA_WIDTH       = DATA_W,
   parameter int unsigned C_TAG_WIDTH        = C_MEM_ADDR_WIDTH - C_CACHE_ADDR_WIDTH,
   parameter int unsigned C_CNT_WIDTH        = CNT_W
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                req_valid,
   output logic                                req_ready,
   input  logic [C_MEM_ADDR_WIDTH-1:0]         req_addr,
   output logic                                rsp_valid,
   input  logic                                rsp_ready,
   output logic [C_DATA_WIDTH-1:0]             rsp_data,
   output logic                                rsp_hit,
   output logic                                cache_rd_en,
   output logic [C_CACHE_ADDR_WIDTH-1:0]       cache_rd_addr,
   output logic [C_TAG_WIDTH-1:0]              cache_rd_din,
   input  logic                                cache_rd_result,
   input  logic [C_DATA_WIDTH-1:0]             cache_rd_dout,
   input  logic                                cache_rd_valid,
   output logic                                cache_wr_en,
   output logic [C_CACHE_ADDR_WIDTH-1:0]       cache_wr_addr,
   output logic [C_DATA_WIDTH+C_TAG_WIDTH-1:0] cache_wr_data,
   output logic                                mem_req_valid,
   input  logic                                mem_req_ready,
   output logic [C_MEM_ADDR_WIDTH-1:0]         mem_req_addr,
   input  logic                                mem_rsp_valid,
   output logic                                mem_rsp_ready,
   input  logic [C_DATA_WIDTH-1:0]             mem_rsp_data,
   input  logic                                stats_clr,
   output logic [C_CNT_WIDTH-1:0]              hit_cnt,
   output logic [C_CNT_WIDTH-1:0]              miss_cnt
);

   state_e                        state_q, state_d;
   logic [C_MEM_ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [C_DATA_WIDTH-1:0]       rsp_data_q, rsp_data_d;
   logic                          rsp_hit_q, rsp_hit_d;
   logic                          req_ready_q, req_ready_d;
   logic                          rsp_valid_q, rsp_valid_d;
   logic                          rd_en_q, rd_en_d;
   logic                          wr_en_q, wr_en_d;
   logic                          mem_req_valid_q, mem_req_valid_d;
   logic                          mem_rsp_ready_q, mem_rsp_ready_d;
   logic                          hit_inc, miss_inc;

   // Next state plus next value of every registered output.
   // Strobes are decoded from state_d so they appear in the cycle the
   // FSM occupies the corresponding state.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rsp_data_d = rsp_data_q;
      rsp_hit_d  = rsp_hit_q;
      hit_inc    = 1'b0;
      miss_inc   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready_q) begin
               addr_d  = req_addr;
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            state_d = S_WAIT_RD;
         end
         S_WAIT_RD: begin
            if (cache_rd_valid) begin
               if (cache_rd_result) begin
                  rsp_data_d = cache_rd_dout;
                  rsp_hit_d  = 1'b1;
                  hit_inc    = 1'b1;
                  state_d    = S_RESP;
               end else begin
                  rsp_hit_d  = 1'b0;
                  miss_inc   = 1'b1;
                  state_d    = S_MEM_REQ;
               end
            end
         end
         S_MEM_REQ: begin
            if (mem_req_valid_q && mem_req_ready) begin
               state_d = S_MEM_WAIT;
            end
         end
         S_MEM_WAIT: begin
            if (mem_rsp_valid && mem_rsp_ready_q) begin
               rsp_data_d = mem_rsp_data;
               state_d    = S_FILL;
            end
         end
         S_FILL: begin
            rsp_hit_d = 1'b0;
            state_d   = S_RESP;
         end
         S_RESP: begin
            if (rsp_valid_q && rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      req_ready_d     = (state_d == S_IDLE);
      rd_en_d         = (state_d == S_LOOKUP);
      mem_req_valid_d = (state_d == S_MEM_REQ);
      mem_rsp_ready_d = (state_d == S_MEM_WAIT);
      wr_en_d         = (state_d == S_FILL);
      rsp_valid_d     = (state_d == S_RESP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= S_IDLE;
         addr_q          <= '0;
         rsp_data_q      <= '0;
         rsp_hit_q       <= 1'b0;
         req_ready_q     <= 1'b0;
         rsp_valid_q     <= 1'b0;
         rd_en_q         <= 1'b0;
         wr_en_q         <= 1'b0;
         mem_req_valid_q <= 1'b0;
         mem_rsp_ready_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         rsp_data_q      <= rsp_data_d;
         rsp_hit_q       <= rsp_hit_d;
         req_ready_q     <= req_ready_d;
         rsp_valid_q     <= rsp_valid_d;
         rd_en_q         <= rd_en_d;
         wr_en_q         <= wr_en_d;
         mem_req_valid_q <= mem_req_valid_d;
         mem_rsp_ready_q <= mem_rsp_ready_d;
      end
   end

   // Address-derived buses are plain slices of the captured request;
   // the fill line reuses the response data register.
   assign req_ready     = req_ready_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_data      = rsp_data_q;
   assign rsp_hit       = rsp_hit_q;
   assign cache_rd_en   = rd_en_q;
   assign cache_rd_addr = addr_q[C_CACHE_ADDR_WIDTH-1:0];
   assign cache_rd_din  = addr_q[C_MEM_ADDR_WIDTH-1:C_CACHE_ADDR_WIDTH];
   assign cache_wr_en   = wr_en_q;
   assign cache_wr_addr = addr_q[C_CACHE_ADDR_WIDTH-1:0];
   assign cache_wr_data = pack_line(rsp_data_q, addr_q[C_MEM_ADDR_WIDTH-1:C_CACHE_ADDR_WIDTH]);
   assign mem_req_valid = mem_req_valid_q;
   assign mem_req_addr  = addr_q;
   assign mem_rsp_ready = mem_rsp_ready_q;

   sat_counter #(.WIDTH(C_CNT_WIDTH)) u_hit_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (stats_clr),
      .inc_i (hit_inc),
      .cnt_o (hit_cnt)
   );

   sat_counter #(.WIDTH(C_CNT_WIDTH)) u_miss_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (stats_clr),
      .inc_i (miss_inc),
      .cnt_o (miss_cnt)
   );

endmodule

// File: tb/tb_hcache_lookup_ctrl.sv
// Directed bench for hcache_lookup_ctrl with a behavioural cache (2-cycle
// lookup) and a behavioural memory (programmable latency). Counters are
// built 4 bits wide so saturation is reachable in a few requests.
module tb_hcache_lookup_ctrl;

   localparam int unsigned CW = 4;

   logic          clk, rst;
   logic          req_valid, req_ready;
   logic [31:0]   req_addr;
   logic          rsp_valid, rsp_ready;
   logic [63:0]   rsp_data;
   logic          rsp_hit;
   logic          cache_rd_en;
   logic [12:0]   cache_rd_addr;
   logic [18:0]   cache_rd_din;
   logic          cache_rd_result;
   logic [63:0]   cache_rd_dout;
   logic          cache_rd_valid;
   logic          cache_wr_en;
   logic [12:0]   cache_wr_addr;
   logic [82:0]   cache_wr_data;
   logic          mem_req_valid, mem_req_ready;
   logic [31:0]   mem_req_addr;
   logic          mem_rsp_valid, mem_rsp_ready;
   logic [63:0]   mem_rsp_data;
   logic          stats_clr;
   logic [CW-1:0] hit_cnt, miss_cnt;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   hcache_lookup_ctrl #(.C_CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_hit(rsp_hit),
      .cache_rd_en(cache_rd_en), .cache_rd_addr(cache_rd_addr), .cache_rd_din(cache_rd_din),
      .cache_rd_result(cache_rd_result), .cache_rd_dout(cache_rd_dout), .cache_rd_valid(cache_rd_valid),
      .cache_wr_en(cache_wr_en), .cache_wr_addr(cache_wr_addr), .cache_wr_data(cache_wr_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data),
      .stats_clr(stats_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- behavioural cache ----------------
   logic        lv [8192];
   logic [18:0] lt [8192];
   logic [63:0] ld [8192];
   logic        pl_en, pl_clr, pl_valid;
   logic [12:0] pl_idx;
   logic [18:0] pl_tag;
   logic [63:0] pl_data;
   logic        p1_v, p1_hit;
   logic [63:0] p1_d;
   int          rd_cnt = 0, wr_cnt = 0;
   logic        both_seen = 1'b0;
   logic [12:0] last_wr_addr;
   logic [82:0] last_wr_data;

   always @(posedge clk) begin
      if (cache_wr_en) begin
         lv[cache_wr_addr] <= 1'b1;
         lt[cache_wr_addr] <= cache_wr_data[18:0];
         ld[cache_wr_addr] <= cache_wr_data[82:19];
         wr_cnt       <= wr_cnt + 1;
         last_wr_addr <= cache_wr_addr;
         last_wr_data <= cache_wr_data;
      end
      if (pl_clr) begin
         for (int i = 0; i < 8192; i++) lv[i] <= 1'b0;
      end
      if (pl_en) begin
         lv[pl_idx] <= pl_valid;
         lt[pl_idx] <= pl_tag;
         ld[pl_idx] <= pl_data;
      end
      if (cache_rd_en) rd_cnt <= rd_cnt + 1;
      if (cache_rd_en && cache_wr_en) both_seen <= 1'b1;
      p1_v            <= cache_rd_en;
      p1_hit          <= lv[cache_rd_addr] && (lt[cache_rd_addr] == cache_rd_din);
      p1_d            <= ld[cache_rd_addr];
      cache_rd_valid  <= p1_v;
      cache_rd_result <= p1_hit;
      cache_rd_dout   <= p1_d;
   end

   // ---------------- behavioural memory ----------------
   int          mem_lat = 2;
   logic [63:0] mem_data_v = 64'h0;
   int          mem_req_cnt = 0;
   logic [31:0] last_mem_addr = 32'h0;
   logic        mem_pend = 1'b0;
   int          mem_wait = 0;

   always @(posedge clk) begin
      if (rst) begin
         mem_rsp_valid <= 1'b0;
         mem_rsp_data  <= 64'h0;
         mem_pend      <= 1'b0;
      end else begin
         if (mem_rsp_valid && mem_rsp_ready) mem_rsp_valid <= 1'b0;
         if (mem_pend) begin
            if (mem_wait == 0) begin
               mem_rsp_valid <= 1'b1;
               mem_rsp_data  <= mem_data_v;
               mem_pend      <= 1'b0;
            end else begin
               mem_wait <= mem_wait - 1;
            end
         end
         if (mem_req_valid && mem_req_ready) begin
            mem_pend      <= 1'b1;
            mem_wait      <= mem_lat;
            mem_req_cnt   <= mem_req_cnt + 1;
            last_mem_addr <= mem_req_addr;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers ----------------
   task automatic preload(input logic [12:0] idx, input logic [18:0] tag,
                          input logic [63:0] data, input logic v);
      @(negedge clk);
      pl_en = 1'b1; pl_idx = idx; pl_tag = tag; pl_data = data; pl_valid = v;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   // Issues one request with rsp_ready high; reports the response and the
   // cycles of accept, memory-data handshake, fill strobe and response.
   task automatic run_req(input logic [31:0] a, output logic [63:0] d, output logic h,
                          output int acc, output int mc, output int wc, output int rc,
                          output bit to);
      int n;
      d = 64'h0; h = 1'b0; acc = -1; mc = -1; wc = -1; rc = -1; to = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_addr = a;
      n = 0;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      if (!req_ready) begin req_valid = 1'b0; to = 1'b1; return; end
      acc = cyc;
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 200) begin
         if (mem_rsp_valid && mem_rsp_ready) mc = cyc;
         if (cache_wr_en) wc = cyc;
         @(negedge clk);
         n++;
      end
      if (!rsp_valid) begin to = 1'b1; return; end
      rc = cyc; d = rsp_data; h = rsp_hit;
      @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      repeat (3) @(negedge clk);
      pl_clr = 1'b0;
      checks++;
      if ({req_ready, rsp_valid, cache_rd_en, cache_wr_en, mem_req_valid, mem_rsp_ready, rsp_hit} !== 7'b0) begin
         failures++;
         $display("FAIL reset_ctrl: got %b expected 0000000", {req_ready, rsp_valid, cache_rd_en, cache_wr_en, mem_req_valid, mem_rsp_ready, rsp_hit});
      end
      checks++;
      if (rsp_data !== 64'h0 || hit_cnt !== 4'h0 || miss_cnt !== 4'h0) begin
         failures++;
         $display("FAIL reset_data: rsp_data=%h hit=%0d miss=%0d expected all 0", rsp_data, hit_cnt, miss_cnt);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         failures++; $display("FAIL reset_ready: got %b expected 1", req_ready);
      end
   endtask

   task automatic test_hit;
      logic [63:0] d; logic h; int acc, mc, wc, rc; bit to; int m0, r0;
      preload(13'h005, 19'h1, 64'hDEAD_BEEF, 1'b1);
      m0 = mem_req_cnt; r0 = rd_cnt;
      run_req(32'h0000_2005, d, h, acc, mc, wc, rc, to);
      checks++;
      if (to !== 1'b0) begin failures++; $display("FAIL hit_timeout: got %b expected 0", to); end
      checks++;
      if (rc - acc !== 4) begin failures++; $display("FAIL hit_latency: got %0d expected 4", rc - acc); end
      checks++;
      if (d !== 64'hDEAD_BEEF || h !== 1'b1) begin
         failures++; $display("FAIL hit_rsp: data=%h hit=%b expected deadbeef/1", d, h);
      end
      checks++;
      if (hit_cnt !== 4'd1 || miss_cnt !== 4'd0) begin
         failures++; $display("FAIL hit_cnt: hit=%0d miss=%0d expected 1/0", hit_cnt, miss_cnt);
      end
      checks++;
      if (mem_req_cnt != m0 || rd_cnt - r0 != 1) begin
         failures++; $display("FAIL hit_ports: mem_reqs=%0d rd_strobes=%0d expected 0/1", mem_req_cnt - m0, rd_cnt - r0);
      end
   endtask

   task automatic test_miss;
      logic [63:0] d; logic h; int acc, mc, wc, rc; bit to; int m0, w0;
      mem_lat = 2; mem_data_v = 64'h1234;
      m0 = mem_req_cnt; w0 = wr_cnt;
      run_req(32'h0000_4007, d, h, acc, mc, wc, rc, to);
      checks++;
      if (to !== 1'b0 || d !== 64'h1234 || h !== 1'b0) begin
         failures++; $display("FAIL miss_rsp: to=%b data=%h hit=%b expected 0/1234/0", to, d, h);
      end
      checks++;
      if (mem_req_cnt - m0 != 1 || last_mem_addr !== 32'h0000_4007) begin
         failures++; $display("FAIL miss_memreq: count=%0d addr=%h expected 1/00004007", mem_req_cnt - m0, last_mem_addr);
      end
      checks++;
      if (wr_cnt - w0 != 1 || last_wr_addr !== 13'h007 || last_wr_data !== {64'h1234, 19'h2}) begin
         failures++; $display("FAIL miss_fill: count=%0d addr=%h data=%h expected 1/007/%h", wr_cnt - w0, last_wr_addr, last_wr_data, {64'h1234, 19'h2});
      end
      checks++;
      if (wc !== mc + 1 || rc !== mc + 2) begin
         failures++; $display("FAIL miss_latency: mem=%0d fill=%0d rsp=%0d expected fill=mem+1 rsp=mem+2", mc, wc, rc);
      end
      checks++;
      if (miss_cnt !== 4'd1) begin failures++; $display("FAIL miss_cnt: got %0d expected 1", miss_cnt); end
      m0 = mem_req_cnt;
      run_req(32'h0000_4007, d, h, acc, mc, wc, rc, to);
      checks++;
      if (to !== 1'b0 || h !== 1'b1 || d !== 64'h1234 || mem_req_cnt != m0) begin
         failures++; $display("FAIL miss_rehit: to=%b hit=%b data=%h memreqs=%0d expected 0/1/1234/0", to, h, d, mem_req_cnt - m0);
      end
      checks++;
      if (hit_cnt !== 4'd2 || miss_cnt !== 4'd1) begin
         failures++; $display("FAIL miss_counts: hit=%0d miss=%0d expected 2/1", hit_cnt, miss_cnt);
      end
   endtask

   task automatic test_backpressure;
      int n; int m0;
      mem_lat = 1; mem_data_v = 64'hCAFE_F00D_0000_0001;
      mem_req_ready = 1'b0; rsp_ready = 1'b0; m0 = mem_req_cnt;
      @(negedge clk);
      req_valid = 1'b1; req_addr = 32'h0000_6009;
      n = 0;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!mem_req_valid && n < 20) begin @(negedge clk); n++; end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_6009 || req_ready !== 1'b0) begin
            failures++; $display("FAIL bp_memreq[%0d]: valid=%b addr=%h ready=%b expected 1/00006009/0", i, mem_req_valid, mem_req_addr, req_ready);
         end
         @(negedge clk);
      end
      mem_req_ready = 1'b1;
      n = 0;
      while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (rsp_valid !== 1'b1 || rsp_data !== 64'hCAFE_F00D_0000_0001 || rsp_hit !== 1'b0 || req_ready !== 1'b0) begin
            failures++; $display("FAIL bp_rsp[%0d]: valid=%b data=%h hit=%b ready=%b expected 1/cafef00d00000001/0/0", i, rsp_valid, rsp_data, rsp_hit, req_ready);
         end
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_req_cnt - m0 != 1 || miss_cnt !== 4'd2) begin
         failures++; $display("FAIL bp_release: valid=%b ready=%b memreqs=%0d miss=%0d expected 0/1/1/2", rsp_valid, req_ready, mem_req_cnt - m0, miss_cnt);
      end
   endtask

   task automatic test_conflict;
      logic [63:0] d; logic h; int acc, mc, wc, rc; bit to;
      preload(13'h005, 19'h0, 64'h0, 1'b0);
      mem_data_v = 64'h1111;
      run_req(32'h0000_2005, d, h, acc, mc, wc, rc, to);
      checks++;
      if (to !== 1'b0 || h !== 1'b0 || last_wr_addr !== 13'h005 || last_wr_data !== {64'h1111, 19'h1}) begin
         failures++; $display("FAIL conflict_first: to=%b hit=%b waddr=%h wdata=%h expected 0/0/005/%h", to, h, last_wr_addr, last_wr_data, {64'h1111, 19'h1});
      end
      mem_data_v = 64'h2222;
      run_req(32'h0000_4005, d, h, acc, mc, wc, rc, to);
      checks++;
      if (to !== 1'b0 || h !== 1'b0 || d !== 64'h2222 || last_wr_addr !== 13'h005 || last_wr_data !== {64'h2222, 19'h2}) begin
         failures++; $display("FAIL conflict_refill: to=%b hit=%b data=%h waddr=%h wdata=%h expected 0/0/2222/005/%h", to, h, d, last_wr_addr, last_wr_data, {64'h2222, 19'h2});
      end
      run_req(32'h0000_4005, d, h, acc, mc, wc, rc, to);
      checks++;
      if (to !== 1'b0 || h !== 1'b1 || d !== 64'h2222 || miss_cnt !== 4'd4 || hit_cnt !== 4'd3) begin
         failures++; $display("FAIL conflict_rehit: to=%b hit=%b data=%h miss=%0d hits=%0d expected 0/1/2222/4/3", to, h, d, miss_cnt, hit_cnt);
      end
   endtask

   task automatic test_reset_mid;
      logic [63:0] d; logic h; int acc, mc, wc, rc; bit to; int n, w0; bit seen;
      mem_lat = 20; mem_data_v = 64'h5555;
      @(negedge clk);
      req_valid = 1'b1; req_addr = 32'h0000_200A;
      n = 0;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!mem_rsp_ready && n < 50) begin @(negedge clk); n++; end
      checks++;
      if (mem_rsp_ready !== 1'b1) begin failures++; $display("FAIL rmid_reach: mem_rsp_ready=%b expected 1", mem_rsp_ready); end
      w0 = wr_cnt;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({req_ready, rsp_valid, rsp_hit, cache_rd_en, cache_wr_en, mem_req_valid, mem_rsp_ready} !== 7'b0
          || rsp_data !== 64'h0 || hit_cnt !== 4'd0 || miss_cnt !== 4'd0) begin
         failures++; $display("FAIL rmid_outputs: ctrl=%b data=%h hit=%0d miss=%0d expected 0/0/0/0",
            {req_ready, rsp_valid, rsp_hit, cache_rd_en, cache_wr_en, mem_req_valid, mem_rsp_ready}, rsp_data, hit_cnt, miss_cnt);
      end
      rst = 1'b0;
      seen = 1'b0;
      repeat (30) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
      checks++;
      if (wr_cnt != w0 || seen !== 1'b0) begin
         failures++; $display("FAIL rmid_drop: fills=%0d rsp_seen=%b expected 0/0", wr_cnt - w0, seen);
      end
      mem_lat = 1; mem_data_v = 64'h0BAD_F00D;
      run_req(32'h0000_200A, d, h, acc, mc, wc, rc, to);
      checks++;
      if (to !== 1'b0 || h !== 1'b0 || d !== 64'h0BAD_F00D || miss_cnt !== 4'd1 || hit_cnt !== 4'd0) begin
         failures++; $display("FAIL rmid_after: to=%b hit=%b data=%h miss=%0d hits=%0d expected 0/0/0badf00d/1/0", to, h, d, miss_cnt, hit_cnt);
      end
   endtask

   task automatic test_stats;
      logic [63:0] d; logic h; int acc, mc, wc, rc; bit to; bit any_to; int n;
      run_req(32'h0000_4005, d, h, acc, mc, wc, rc, to);
      checks++;
      if (to !== 1'b0 || h !== 1'b1 || hit_cnt !== 4'd1) begin
         failures++; $display("FAIL stats_pre: to=%b hit=%b hits=%0d expected 0/1/1", to, h, hit_cnt);
      end
      // Clear pulse lands in the same cycle as the hit increment.
      @(negedge clk);
      req_valid = 1'b1; req_addr = 32'h0000_4005;
      n = 0;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!cache_rd_valid && n < 20) begin @(negedge clk); n++; end
      stats_clr = 1'b1;
      @(negedge clk);
      stats_clr = 1'b0;
      n = 0;
      while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_hit !== 1'b1 || hit_cnt !== 4'd0 || miss_cnt !== 4'd0) begin
         failures++; $display("FAIL stats_clr_prio: valid=%b hit=%b hits=%0d miss=%0d expected 1/1/0/0", rsp_valid, rsp_hit, hit_cnt, miss_cnt);
      end
      @(negedge clk);
      any_to = 1'b0;
      for (int i = 0; i < 15; i++) begin
         run_req(32'h0000_4005, d, h, acc, mc, wc, rc, to);
         if (to) any_to = 1'b1;
      end
      checks++;
      if (any_to !== 1'b0 || hit_cnt !== 4'hF) begin
         failures++; $display("FAIL stats_fill: to=%b hits=%0d expected 0/15", any_to, hit_cnt);
      end
      run_req(32'h0000_4005, d, h, acc, mc, wc, rc, to);
      checks++;
      if (to !== 1'b0 || h !== 1'b1 || hit_cnt !== 4'hF) begin
         failures++; $display("FAIL stats_saturate: to=%b hit=%b hits=%0d expected 0/1/15", to, h, hit_cnt);
      end
   endtask

   task automatic test_port_rules;
      checks++;
      if (both_seen !== 1'b0) begin
         failures++; $display("FAIL port_rd_wr_overlap: got %b expected 0", both_seen);
      end
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_addr = 32'h0; rsp_ready = 1'b1;
      mem_req_ready = 1'b1; stats_clr = 1'b0;
      pl_en = 1'b0; pl_clr = 1'b1; pl_valid = 1'b0; pl_idx = 13'h0; pl_tag = 19'h0; pl_data = 64'h0;
      test_reset;
      test_hit;
      test_miss;
      test_backpressure;
      test_conflict;
      test_reset_mid;
      test_stats;
      test_port_rules;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hcache_lookup_ctrl.md
Name: hcache_lookup_ctrl

Overview:
- Initiator-side controller for the small direct-mapped hash cache; drives the cache's port-0 read (lookup) and write (fill) path.
- Accepts one key-address lookup at a time. On hit, returns the cached data. On miss, fetches from backing memory (DRAM/host table), fills the cache line and returns the fetched data.
- Sits between the key-hash pipeline (upstream) and the cache plus memory request arbiter (downstream).

Parameters:
- C_MEM_ADDR_WIDTH, 32, full memory/key address width.
- C_CACHE_ADDR_WIDTH, 13, cache index width (low address bits).
- C_DATA_WIDTH, 64, cached data width.
- C_TAG_WIDTH, C_MEM_ADDR_WIDTH-C_CACHE_ADDR_WIDTH, tag width (high address bits).
- C_CNT_WIDTH, 32, statistics counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  lookup request valid.
- req_ready  out  1  controller can accept a request.
- req_addr  in  C_MEM_ADDR_WIDTH  lookup address.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  downstream accepts response.
- rsp_data  out  C_DATA_WIDTH  returned data.
- rsp_hit  out  1  1 = served from cache, 0 = filled from memory.
- cache_rd_en  out  1  cache lookup strobe.
- cache_rd_addr  out  C_CACHE_ADDR_WIDTH  lookup index.
- cache_rd_din  out  C_TAG_WIDTH  tag to compare.
- cache_rd_result  in  1  hit flag; valid only while cache_rd_valid=1.
- cache_rd_dout  in  C_DATA_WIDTH  cached data; valid only while cache_rd_valid=1.
- cache_rd_valid  in  1  lookup result valid, 2 cycles after cache_rd_en.
- cache_wr_en  out  1  fill strobe.
- cache_wr_addr  out  C_CACHE_ADDR_WIDTH  fill index.
- cache_wr_data  out  C_DATA_WIDTH+C_TAG_WIDTH  {data, tag}, tag in the low bits.
- mem_req_valid  out  1  memory read request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  C_MEM_ADDR_WIDTH  memory read address.
- mem_rsp_valid  in  1  memory read data valid.
- mem_rsp_ready  out  1  controller accepts read data.
- mem_rsp_data  in  C_DATA_WIDTH  memory read data.
- stats_clr  in  1  clear the statistics counters.
- hit_cnt  out  C_CNT_WIDTH  hit count, saturating.
- miss_cnt  out  C_CNT_WIDTH  miss count, saturating.

Behaviour:
- Registered request: index = addr[C_CACHE_ADDR_WIDTH-1:0]; tag = addr[C_MEM_ADDR_WIDTH-1:C_CACHE_ADDR_WIDTH].
- All outputs are registered.
- Reset values: state=IDLE; every valid/strobe/ready output = 0; rsp_data=0; rsp_hit=0; counters=0.
- req_ready is 1 only in IDLE.
- FSM states: IDLE, LOOKUP, WAIT_RD, MEM_REQ, MEM_WAIT, FILL, RESP.
- IDLE: on req_valid&&req_ready, capture req_addr and go to LOOKUP.
- LOOKUP: cache_rd_en=1 for exactly one cycle with index/tag; go to WAIT_RD.
- WAIT_RD: wait for cache_rd_valid. Then:
  - cache_rd_result=1: latch cache_rd_dout, rsp_hit=1, hit_cnt++, go to RESP.
  - cache_rd_result=0: miss_cnt++, go to MEM_REQ.
- MEM_REQ: hold mem_req_valid=1 and mem_req_addr=captured address until mem_req_ready; go to MEM_WAIT.
- MEM_WAIT: mem_rsp_ready=1; on mem_rsp_valid, latch data and go to FILL. mem_rsp_ready=0 in every other state.
- FILL: cache_wr_en=1 for one cycle with {mem data, tag} at the index; rsp_hit=0; go to RESP.
- RESP: hold rsp_valid, rsp_data and rsp_hit stable until rsp_ready; return to IDLE. The next request may be accepted no earlier than the following cycle.
- Port rules:
  - cache_rd_en and cache_wr_en are never asserted in the same cycle.
  - cache_rd_en is asserted at most once per request.
- Hit latency: request accepted at cycle N → cache_rd_en at N+1, cache_rd_valid at N+3, rsp_valid at N+4.
- Miss with mem_req_ready=1 and memory response at cycle M → cache_wr_en at M+1, rsp_valid at M+2.
- cache_rd_valid outside WAIT_RD is ignored.
- Counters:
  - Saturate at all-ones.
  - stats_clr has priority over an increment in the same cycle.
- Reset mid-operation: return to IDLE and drop any in-flight request without response or fill. The memory side is reset on the same rst.

Decomposition:
- Shared package hcache_pkg: state enum, tag/index width localparams, {data, tag} line-packing function.
- Sub-module sat_counter (width parameter, inc, clr), instantiated twice.

Test Plan:
- Hit: preload cache line index 0x005 with tag 0x1, data 0xDEAD_BEEF; request 0x0000_2005 → rsp_valid at N+4, rsp_data=0xDEADBEEF, rsp_hit=1, hit_cnt=1, no mem_req_valid.
- Miss: empty cache; request 0x0000_4007; memory returns 0x1234 → single mem_req at addr 0x4007; cache_wr_en with addr 0x007, data {0x1234, tag 0x2}; rsp_hit=0; miss_cnt=1; repeating the request → hit.
- Backpressure: mem_req_ready low 5 cycles and rsp_ready low 3 cycles → mem_req_valid/addr and rsp_valid/data held stable; req_ready=0 throughout.
- Conflict: miss on 0x0000_2005, then request 0x0000_4005 → second request misses and refills index 0x005 with tag 0x2.
- Reset during MEM_WAIT → all outputs return to reset values next cycle, no fill, counters=0; a new request then completes normally.
- Saturation/clear: force counter to all-ones and apply a hit → stays all-ones; stats_clr coincident with a hit → hit_cnt=0.
